// File: rtl/akuma_pkg.sv
// Shared types and constants for the Akuma motion controller.
// Build option: AKUMA_AIR_CONTROL_EN enables left/right steering during a jump.
package akuma_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int SPRITE_W   = 184;
    localparam int SPRITE_H   = 240;
    localparam int START_X    = 64;
    localparam int WALK_SPEED = 3;
    localparam int JUMP_V     = 16;
    localparam int GRAVITY    = 1;
    localparam int PUNCH_SU   = 4;
    localparam int PUNCH_ACT  = 3;
    localparam int PUNCH_REC  = 6;

    localparam logic [9:0] GROUND_Y = 10'(SCREEN_H - SPRITE_H);
    localparam logic [9:0] X_MAX    = 10'(SCREEN_W - SPRITE_W);
    localparam logic [9:0] X_START  = 10'(START_X);

    localparam logic [2:0] CNT_SU  = 3'(PUNCH_SU - 1);
    localparam logic [2:0] CNT_ACT = 3'(PUNCH_ACT - 1);
    localparam logic [2:0] CNT_REC = 3'(PUNCH_REC - 1);

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_WALK  = 2'd1,
        P_PUNCH = 2'd2,
        P_JUMP  = 2'd3
    } pose_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WALK,
        S_PUNCH_SU,
        S_PUNCH_ACT,
        S_PUNCH_REC,
        S_JUMP
    } motion_state_t;

    function automatic pose_t pose_of(input motion_state_t s);
        case (s)
            S_WALK:                              return P_WALK;
            S_PUNCH_SU, S_PUNCH_ACT, S_PUNCH_REC: return P_PUNCH;
            S_JUMP:                              return P_JUMP;
            default:                             return P_IDLE;
        endcase
    endfunction

    // Horizontal step, clamped to the visible sprite range.
    function automatic logic [9:0] x_step(input logic [9:0] x,
                                          input logic       right,
                                          input logic [9:0] spd);
        logic [10:0] s;
        s = {1'b0, x} + {1'b0, spd};
        if (right)
            return (s > {1'b0, X_MAX}) ? X_MAX : s[9:0];
        return (x < spd) ? 10'd0 : x - spd;
    endfunction

endpackage

// File: rtl/akuma_motion_ctrl_vsync_edge.sv
// Frame tick generator: one vga_clk-wide pulse per vsync falling edge.
// Build option: none.
module vsync_edge_detect (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic vsync,
    output logic frame_tick
);

    logic vs_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) vs_q <= 1'b1;
        else          vs_q <= vsync;
    end

    assign frame_tick = vs_q & ~vsync;

endmodule

// File: rtl/akuma_motion_ctrl.sv
// Per-frame Akuma FSM: idle/walk/punch/jump, sprite position, pose, hitbox.
// Build option: AKUMA_AIR_CONTROL_EN (air steering at WALK_SPEED/2 per frame).
module akuma_motion_ctrl
    import akuma_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_punch,
    input  logic       btn_jump,
    output logic [9:0] AkumaX,
    output logic [9:0] AkumaY,
    output logic [1:0] pose,
    output logic       punch_active
);

    logic                frame_tick;
    motion_state_t       state_q, state_d;
    logic [9:0]          x_q, x_d;
    logic [9:0]          y_q, y_d;
    logic signed [6:0]   vy_q, vy_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                pp_q, pp_d;
    pose_t               pose_q, pose_d;
    logic                act_q, act_d;
    logic                press, one_dir;
    logic signed [10:0]  y_nxt;

    vsync_edge_detect u_vs (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    assign press   = btn_punch & ~pp_q;
    assign one_dir = btn_left ^ btn_right;
    assign y_nxt   = $signed({1'b0, y_q}) + 11'(vy_q);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        cnt_d   = cnt_q;
        pp_d    = pp_q;
        if (frame_tick) begin
            pp_d = btn_punch;
            unique case (state_q)
                S_IDLE, S_WALK: begin
                    if (press) begin
                        state_d = S_PUNCH_SU;
                        cnt_d   = CNT_SU;
                    end else if (btn_jump) begin
                        state_d = S_JUMP;
                        y_d     = y_q - 10'(JUMP_V);
                        vy_d    = 7'(GRAVITY - JUMP_V);
                    end else if (one_dir) begin
                        state_d = S_WALK;
                        x_d     = x_step(x_q, btn_right, 10'(WALK_SPEED));
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PUNCH_SU: begin
                    if (cnt_q == 3'd0) begin
                        state_d = S_PUNCH_ACT;
                        cnt_d   = CNT_ACT;
                    end else cnt_d = cnt_q - 3'd1;
                end
                S_PUNCH_ACT: begin
                    if (cnt_q == 3'd0) begin
                        state_d = S_PUNCH_REC;
                        cnt_d   = CNT_REC;
                    end else cnt_d = cnt_q - 3'd1;
                end
                S_PUNCH_REC: begin
                    if (cnt_q == 3'd0) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                S_JUMP: begin
                    if (vy_q > 7'sd0 && y_nxt >= $signed({1'b0, GROUND_Y})) begin
                        state_d = S_IDLE;
                        y_d     = GROUND_Y;
                        vy_d    = '0;
                    end else begin
                        y_d  = y_nxt[10] ? 10'd0 : y_nxt[9:0];
                        vy_d = vy_q + 7'(GRAVITY);
                    end
`ifdef AKUMA_AIR_CONTROL_EN
                    if (one_dir)
                        x_d = x_step(x_q, btn_right, 10'(WALK_SPEED / 2));
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
        pose_d = pose_of(state_d);
        act_d  = (state_d == S_PUNCH_ACT);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            x_q     <= X_START;
            y_q     <= GROUND_Y;
            vy_q    <= '0;
            cnt_q   <= '0;
            pp_q    <= 1'b0;
            pose_q  <= P_IDLE;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            cnt_q   <= cnt_d;
            pp_q    <= pp_d;
            pose_q  <= pose_d;
            act_q   <= act_d;
        end
    end

    assign AkumaX       = x_q;
    assign AkumaY       = y_q;
    assign pose         = pose_q;
    assign punch_active = act_q;

endmodule

// File: tb/tb_akuma_motion_ctrl.sv
// Randomized bench for akuma_motion_ctrl against a frame-level reference model.
// Build option: AKUMA_AIR_CONTROL_EN must match the DUT build.
module tb_akuma_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       bl, br, bp, bj;
    logic [9:0] ax, ay;
    logic [1:0] pose;
    logic       pact;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: mode 0 idle, 1 walk, 2 punch, 3 jump
    int m_x, m_y, m_vy, m_mode, m_age;
    bit m_pp;

    always #5 clk = ~clk;

    akuma_motion_ctrl dut (
        .vga_clk      (clk),
        .reset_n      (rst_n),
        .vsync        (vsync),
        .btn_left     (bl),
        .btn_right    (br),
        .btn_punch    (bp),
        .btn_jump     (bj),
        .AkumaX       (ax),
        .AkumaY       (ay),
        .pose         (pose),
        .punch_active (pact)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampx(input int v);
        if (v < 0)   return 0;
        if (v > 456) return 456;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 64; m_y = 240; m_vy = 0; m_mode = 0; m_age = 0; m_pp = 0;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit p, input bit j);
        bit press;
        int ny;
        press = p && !m_pp;
        m_pp  = p;
        if (m_mode == 2) begin
            m_age++;
            if (m_age > 13) m_mode = 0;
        end else if (m_mode == 3) begin
            ny = m_y + m_vy;
            if (m_vy > 0 && ny >= 240) begin
                m_y = 240; m_vy = 0; m_mode = 0;
            end else begin
                m_y = (ny < 0) ? 0 : ny;
                m_vy = m_vy + 1;
            end
`ifdef AKUMA_AIR_CONTROL_EN
            if (l != r) m_x = clampx(m_x + (r ? 1 : -1));
`endif
        end else if (press) begin
            m_mode = 2; m_age = 1;
        end else if (j) begin
            m_mode = 3; m_vy = -16; m_y = m_y + m_vy; m_vy = m_vy + 1;
        end else if (l != r) begin
            m_mode = 1; m_x = clampx(m_x + (r ? 3 : -3));
        end else begin
            m_mode = 0;
        end
    endtask

    function automatic int exp_act();
        return (m_mode == 2 && m_age >= 5 && m_age <= 7) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_x"}, int'(ax), m_x);
        chk({tag, "_y"}, int'(ay), m_y);
        chk({tag, "_pose"}, int'(pose), m_mode);
        chk({tag, "_act"}, int'(pact), exp_act());
    endtask

    // One video frame: mid-frame hold check, vsync fall, post-tick check.
    task automatic tick(input bit l, input bit r, input bit p, input bit j);
        @(negedge clk);
        bl = l; br = r; bp = p; bj = j;
        chk("hold_x", int'(ax), m_x);
        chk("hold_pose", int'(pose), m_mode);
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        #1;
        model_tick(l, r, p, j);
        check_all("tick");
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b1;
    endtask

    initial begin
        int cnt_p, cnt_a, k;
        rst_n = 1'b0; vsync = 1'b1;
        bl = 0; br = 0; bp = 0; bj = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        tick(0, 0, 0, 0);
        check_all("idle");
        chk("idle_x_abs", int'(ax), 64);

        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
        chk("walk10_x", int'(ax), 94);
        chk("walk10_pose", int'(pose), 1);
        tick(0, 0, 0, 0);
        chk("release_pose", int'(pose), 0);

        for (int i = 0; i < 130; i++) tick(0, 1, 0, 0);
        chk("clamp_r_x", int'(ax), 456);
        chk("clamp_r_pose", int'(pose), 1);
        tick(1, 1, 0, 0);
        chk("both_x", int'(ax), 456);
        chk("both_pose", int'(pose), 0);

        cnt_p = 0; cnt_a = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, 1, 0);
            if (pose == 2'd2) cnt_p++;
            if (pact) cnt_a++;
        end
        chk("punch_len", cnt_p, 13);
        chk("punch_act_len", cnt_a, 3);
        tick(0, 0, 0, 0);

        tick(0, 0, 0, 1);
        chk("jump_t1", int'(ay), 224);
        tick(0, 0, 0, 0);
        chk("jump_t2", int'(ay), 209);
        k = 2;
        while (k < 33) begin
            tick(0, 0, 1, 1);
            k++;
        end
        chk("land_y", int'(ay), 240);
        chk("land_pose", int'(pose), 0);
        tick(0, 0, 0, 0);

        for (int i = 0; i < 500; i++) begin
            int rl, rr, rp, rj;
            rl = ($urandom_range(0, 2) == 0) ? 1 : 0;
            rr = ($urandom_range(0, 1) == 0) ? 1 : 0;
            rp = ($urandom_range(0, 5) == 0) ? 1 : 0;
            rj = ($urandom_range(0, 9) == 0) ? 1 : 0;
            tick(rl[0], rr[0], rp[0], rj[0]);
        end

        tick(0, 0, 0, 0);
        while (m_mode != 0) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
